// File: rtl/tx_frame_control_if.sv
// tx_frame_control_if: request, bus-state and serial-line signals of the frame transmitter.
interface tx_frame_control_if;
    logic        Tx_En_Sig;
    logic [31:0] Tx_Data;
    logic        bus_idle;
    logic        Tx_Cancel;
    logic        Tx_Pin_Out;
    logic        Tx_Pin_to_Rx;
    logic        Tx_Transmit_now;
    logic        Tx_Busy;
    logic        Tx_Done_Sig;
    logic        Tx_Fail_Sig;

    modport master (
        output Tx_En_Sig, Tx_Data, bus_idle, Tx_Cancel,
        input  Tx_Pin_Out, Tx_Pin_to_Rx, Tx_Transmit_now, Tx_Busy, Tx_Done_Sig, Tx_Fail_Sig
    );

    modport slave (
        input  Tx_En_Sig, Tx_Data, bus_idle, Tx_Cancel,
        output Tx_Pin_Out, Tx_Pin_to_Rx, Tx_Transmit_now, Tx_Busy, Tx_Done_Sig, Tx_Fail_Sig
    );
endinterface

// File: rtl/tx_frame_control.sv
// tx_frame_control: serialises a 32-bit word onto the shared line (start, 32 data LSB first, 2 stop),
// releasing the bus and retrying after a growing backoff when a collision is reported.
module tx_frame_control #(
    parameter int CLKS_PER_BIT = 434,
    parameter int BACKOFF_BITS = 8,
    parameter int MAX_RETRY    = 3
) (
    input logic               CLK,
    input logic               RSTn,
    tx_frame_control_if.slave bus
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(MAX_RETRY * BACKOFF_BITS + 1);

    typedef enum logic [2:0] {IDLE, WAIT_BUS, START, DATA, STOP, DONE, BACKOFF, FAIL} state_t;

    state_t        state;
    logic [31:0]   shreg;
    logic [TW-1:0] timer;
    logic [4:0]    bit_idx;
    logic [3:0]    retry_cnt;
    logic [BW-1:0] bo_cnt;
    logic          pin, tnow, busy, done, fail;
    logic          bit_end, bo_end;
    logic [4:0]    retry_nx;

    always_comb begin
        bit_end  = timer == TW'(CLKS_PER_BIT - 1);
        bo_end   = bo_cnt == BW'(int'(retry_cnt) * BACKOFF_BITS - 1);
        retry_nx = {1'b0, retry_cnt} + 5'd1;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            shreg     <= '0;
            timer     <= '0;
            bit_idx   <= '0;
            retry_cnt <= '0;
            bo_cnt    <= '0;
            pin       <= 1'b1;
            tnow      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
        end else begin
            done  <= 1'b0;
            fail  <= 1'b0;
            timer <= bit_end ? '0 : timer + TW'(1);
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (bus.Tx_En_Sig) begin
                        shreg     <= bus.Tx_Data;
                        retry_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= WAIT_BUS;
                    end
                end
                WAIT_BUS: begin
                    timer <= '0;
                    if (bus.bus_idle) begin
                        state <= START;
                        pin   <= 1'b0;
                        tnow  <= 1'b1;
                    end
                end
                START, DATA: begin
                    // a collision outranks a coincident bit boundary
                    if (bus.Tx_Cancel) begin
                        pin       <= 1'b1;
                        tnow      <= 1'b0;
                        retry_cnt <= retry_nx[3:0];
                        timer     <= '0;
                        bo_cnt    <= '0;
                        if (retry_nx > 5'(MAX_RETRY)) begin
                            state <= FAIL;
                            fail  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= BACKOFF;
                        end
                    end else if (bit_end) begin
                        if (state == START) begin
                            state   <= DATA;
                            bit_idx <= '0;
                            pin     <= shreg[0];
                        end else if (bit_idx == 5'd31) begin
                            state   <= STOP;
                            bit_idx <= '0;
                            pin     <= 1'b1;
                            tnow    <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 5'd1;
                            pin     <= shreg[bit_idx + 5'd1];
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (bit_idx == 5'd1) begin
                            state   <= DONE;
                            bit_idx <= '0;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 5'd1;
                        end
                    end
                end
                BACKOFF: begin
                    if (bit_end) begin
                        if (bo_end) state <= WAIT_BUS;
                        else bo_cnt <= bo_cnt + BW'(1);
                    end
                end
                DONE, FAIL: begin
                    timer <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Tx_Pin_Out      = pin;
    assign bus.Tx_Pin_to_Rx    = pin;
    assign bus.Tx_Transmit_now = tnow;
    assign bus.Tx_Busy         = busy;
    assign bus.Tx_Done_Sig     = done;
    assign bus.Tx_Fail_Sig     = fail;
endmodule
